// File: rtl/rd_ptr_ctrl_pkg.sv
// Shared constants and Gray/binary helpers for the FIFO pointer controllers.
package rd_ptr_ctrl_pkg;

   // Widest pointer the helpers handle; callers cast down to their own width.
   localparam int unsigned PTR_MAX_W = 32;

   // Address width for a power-of-two FIFO depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Binary to reflected Gray code.
   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code to binary (prefix XOR from the MSB down).
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_ptr_ctrl_ptr_sync.sv
// N-stage, W-bit flop synchroniser for a Gray pointer crossing clock domains.
module ptr_sync #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stg [N];

   // Shift the asynchronous input through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N); i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int i = 1; i < int'(N); i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[N-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer and flag controller for the asynchronous FIFO.
module rd_ptr_ctrl
   import rd_ptr_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AE_THRESH   = 2,
   localparam int unsigned PW         = ptr_width(DEPTH),
   localparam int unsigned PTRW       = PW + 1
) (
   input  logic            rd_clk,
   input  logic            rst,
   input  logic            rd_en,
   input  logic [PTRW-1:0] wr_ptr_gray,
   output logic [PW-1:0]   rd_addr,
   output logic [PTRW-1:0] rd_ptr_gray,
   output logic            rd_ack,
   output logic            empty,
   output logic            almost_empty,
   output logic [PTRW-1:0] rd_level,
   output logic            underflow
);

   logic [PTRW-1:0] wq_gray;
   logic [PTRW-1:0] wq_bin;
   logic [PTRW-1:0] rd_ptr;
   logic [PTRW-1:0] rd_ptr_next;
   logic [PTRW-1:0] rd_ptr_gray_next;
   logic [PTRW-1:0] level_next;
   logic            rd_go;

   // Bring the write pointer into the read domain.
   ptr_sync #(
      .N (SYNC_STAGES),
      .W (PTRW)
   ) u_wr_sync (
      .clk (rd_clk),
      .rst (rst),
      .d   (wr_ptr_gray),
      .q   (wq_gray)
   );

   // Next pointer, its Gray copy and the fill level seen after this edge.
   always_comb begin
      wq_bin           = PTRW'(gray2bin(PTR_MAX_W'(wq_gray)));
      rd_go            = rd_en & ~empty;
      rd_ptr_next      = rd_ptr + PTRW'(rd_go);
      rd_ptr_gray_next = PTRW'(bin2gray(PTR_MAX_W'(rd_ptr_next)));
      level_next       = wq_bin - rd_ptr_next;
   end

   // Pointer and flag registers; the extra pointer MSB distinguishes full from empty.
   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         rd_ptr_gray  <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         rd_ack       <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         rd_ptr       <= rd_ptr_next;
         rd_ptr_gray  <= rd_ptr_gray_next;
         empty        <= (rd_ptr_gray_next == wq_gray);
         almost_empty <= (level_next <= PTRW'(AE_THRESH));
         rd_level     <= level_next;
         rd_ack       <= rd_go;
         underflow    <= rd_en & empty;
      end
   end

   assign rd_addr = rd_ptr[PW-1:0];

endmodule

// File: doc/rd_ptr_ctrl.md
Name: rd_ptr_ctrl

Overview:
Read-domain pointer and flag controller for the asynchronous FIFO. It is the registered successor of the combinational read circuit. It synchronises the write-domain Gray pointer, owns the read pointer and its Gray copy, and produces registered empty, almost-empty, fill level and underflow indications. It sits between the dual-port RAM read port and the write-domain full logic.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
SYNC_STAGES, 2, flops in the write-pointer synchroniser; >= 2
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; range 0..DEPTH-1

Ports:
rd_clk  in  1  read-domain clock
rst  in  1  asynchronous, active-high reset
rd_en  in  1  read request from consumer
wr_ptr_gray  in  PW+1  write pointer, Gray, from write domain (asynchronous to rd_clk); PW = $clog2(DEPTH)
rd_addr  out  PW  RAM read address = rd_ptr[PW-1:0]
rd_ptr_gray  out  PW+1  registered Gray read pointer, to write-domain synchroniser
rd_ack  out  1  pulses 1 cycle when a read is accepted
empty  out  1  registered empty flag
almost_empty  out  1  registered, level <= AE_THRESH
rd_level  out  PW+1  registered entries available, 0..DEPTH
underflow  out  1  1-cycle pulse: rd_en while empty

Behaviour:
- Reset (async assert, sync release): all sync flops 0, rd_ptr 0, rd_ptr_gray 0, empty 1, almost_empty 1, rd_level 0, rd_ack 0, underflow 0.
- Synchroniser: wr_ptr_gray passes through SYNC_STAGES flops on rd_clk. The last stage output is wq_gray, converted to binary wq_bin.
- Accept: rd_go = rd_en & ~empty.
  - rd_ptr_next = rd_ptr + rd_go, modulo 2^(PW+1); the extra MSB carries the wrap.
  - rd_ptr_gray_next = bin2gray(rd_ptr_next).
  - Both are registered every edge.
- empty <= (rd_ptr_gray_next == wq_gray). The comparison includes the MSB, so an unwrapped pointer pair never reads as empty incorrectly.
- rd_level <= (wq_bin - rd_ptr_next), modulo 2^(PW+1). A value of DEPTH is legal (full as seen from the read side).
- almost_empty <= (level_next <= AE_THRESH), using the same level_next as rd_level.
- rd_ack <= rd_go. The data at rd_addr before the edge is the word consumed, so RAM read latency is the RAM's concern.
- underflow <= rd_en & empty. The pointer does not move on underflow.
- Latency:
  - A write-pointer change becomes visible in empty/rd_level after SYNC_STAGES+1 rd_clk edges.
  - A read updates empty, rd_level and rd_ptr_gray on the same edge that accepts it.
- Wrap: after 2*DEPTH reads, rd_ptr returns to 0. Gray encoding guarantees exactly one bit toggles per increment, including at the wrap.
- Simultaneous read and write arrival: level_next uses the new wq_bin and rd_ptr_next together. A net-zero change keeps rd_level unchanged.
- Last entry read: empty asserts on the accepting edge. A rd_en on the next cycle gives underflow=1, rd_ack=0.
- Reset mid-operation: all state clears immediately. The write domain must be reset concurrently; a stale wr_ptr_gray flushes through the synchroniser within SYNC_STAGES edges after release.
- No combinational path from wr_ptr_gray to any output.

Decomposition:
- Shared package holds:
  - the pointer-width constant function (PW = $clog2(DEPTH))
  - bin2gray/gray2bin functions, or reuse of the existing Gray2Binary and Binary2Gray converters at width PW+1.
- One sub-module: ptr_sync, a parametrised N-stage, W-bit flop synchroniser with async active-high reset. The write-side controller reuses it.

Test Plan:
- Reset with wr_ptr_gray=0 -> empty=1, almost_empty=1, rd_level=0, rd_ptr_gray=0; rd_en=1 -> underflow pulse, rd_addr stays 0.
- wr_ptr_gray steps 0->1 (binary 1) -> empty falls exactly 3 edges later, rd_level=1, almost_empty=1.
- wr_ptr binary 5 synced, rd_en held 5 cycles -> rd_level 4,3,2,1,0; almost_empty rises when level=2; empty rises on 5th accepting edge; rd_ack 5 pulses.
- Wrap: 16 writes and 16 reads interleaved -> rd_ptr_gray sequence single-bit changes, returns to 0; rd_addr cycles 0..7 twice; no false empty.
- wr_ptr binary 8 with rd_ptr 0 (full) -> rd_level=8, empty=0, almost_empty=0; one read -> rd_level=7.
- Assert rst mid-burst with rd_level=6 -> outputs return to reset values asynchronously, before the next rd_clk edge.
